// File: rtl/rx_controller.sv
`default_nettype none
// rx_controller: oversampled async serial receiver (start/data/stop/break) with
// read handshake, sticky framing-error and overrun flags. Rev 1.0
module rx_controller #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 char_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 done;
  logic                 stop_bad;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    done     = 1'b0;
    stop_bad = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!serial_in) state_d = S_START;
      end
      S_START: begin
        // Re-check the line at mid start bit to reject glitches
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (serial_in) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {serial_in, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = S_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (serial_in) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (serial_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A read acknowledged on the completion edge frees the buffer for the new character
  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (done) begin
      if (!ready_q || rd_ack) begin
        data_d  = shift_q;
        ready_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd_ack) begin
      ready_d = 1'b0;
      ovr_d   = 1'b0;
      ferr_d  = 1'b0;
    end
    if (stop_bad) ferr_d = 1'b1;
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    data_out    = data_q;
    char_ready  = ready_q;
    framing_err = ferr_q;
    overrun     = ovr_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_controller.sv
`default_nettype none
// tb_rx_controller: directed frames against a timing-arithmetic receiver model.
module tb_rx_controller;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int M_IDLE  = 0;
  localparam int M_FRAME = 1;
  localparam int M_BRK   = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          serial_in;
  logic          rd_ack;
  logic [DB-1:0] data_out;
  logic          char_ready;
  logic          framing_err;
  logic          overrun;
  logic          busy;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  rx_controller #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_in  (serial_in),
    .rd_ack     (rd_ack),
    .data_out   (data_out),
    .char_ready (char_ready),
    .framing_err(framing_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: positions of the sample points are derived from the start-detect edge
  int            m_mode = M_IDLE;
  int            m_edge = 0;
  int            m_t0   = 0;
  logic [DB-1:0] m_char = '0;
  logic [DB-1:0] m_data = '0;
  logic          m_rdy  = 1'b0;
  logic          m_ferr = 1'b0;
  logic          m_ovr  = 1'b0;

  always @(posedge clk) begin
    bit comp;
    bit ferr;
    int rel;
    comp = 1'b0;
    ferr = 1'b0;
    if (!reset) begin
      m_mode = M_IDLE;
      m_char = '0;
      m_data = '0;
      m_rdy  = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (!serial_in) begin
          m_mode = M_FRAME;
          m_t0   = m_edge;
        end
        M_FRAME: begin
          rel = m_edge - m_t0;
          if (rel == OS/2) begin
            if (serial_in) m_mode = M_IDLE;
          end else if (rel == OS/2 + (DB+1)*OS) begin
            if (serial_in) begin
              comp   = 1'b1;
              m_mode = M_IDLE;
            end else begin
              ferr   = 1'b1;
              m_mode = M_BRK;
            end
          end else if (rel > OS/2 && (rel - OS/2) % OS == 0) begin
            m_char[(rel - OS/2)/OS - 1] = serial_in;
          end
        end
        default: if (serial_in) m_mode = M_IDLE;
      endcase
      if (comp) begin
        if (!m_rdy || rd_ack) begin
          m_data = m_char;
          m_rdy  = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (rd_ack) begin
        m_rdy  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
      end
      if (ferr) m_ferr = 1'b1;
    end
    m_edge++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc data_out", data_out, m_data);
      check("cyc char_ready", char_ready, m_rdy);
      check("cyc framing_err", framing_err, m_ferr);
      check("cyc overrun", overrun, m_ovr);
      check("cyc busy", busy, m_mode != M_IDLE);
    end
  end

  // All tasks assume they are entered just after a falling clock edge
  task automatic send_frame(input logic [DB-1:0] d, input logic stop);
    serial_in = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      serial_in = d[i];
      repeat (OS) @(negedge clk);
    end
    serial_in = stop;
    repeat (OS) @(negedge clk);
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse;
    rd_ack = 1'b1;
    @(negedge clk);
    rd_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [DB-1:0] d, input logic r,
                           input logic fe, input logic ov, input logic b);
    check({tag, " data_out"}, data_out, d);
    check({tag, " char_ready"}, char_ready, r);
    check({tag, " framing_err"}, framing_err, fe);
    check({tag, " overrun"}, overrun, ov);
    check({tag, " busy"}, busy, b);
  endtask

  initial begin
    logic [4:0] part;
    serial_in = 1'b1;
    rd_ack    = 1'b0;
    reset     = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    idle(4);

    // 0xA5 with latency measured from the start-detect edge
    fork
      send_frame(8'hA5, 1'b1);
      begin
        int k;
        k = 0;
        @(posedge clk);
        #1;
        while (!char_ready && k < 400) begin
          @(posedge clk);
          #1;
          k++;
        end
        check("latency", k, 152);
      end
    join
    check_all("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    ack_pulse();
    check("a5 ack char_ready", char_ready, 1'b0);

    // 3-clock glitch
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch busy mid", busy, 1'b1);
    repeat (10) @(negedge clk);
    check_all("glitch", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bad stop bit then break, then a good frame
    send_frame(8'h3C, 1'b0);
    repeat (3*OS) @(negedge clk);
    check_all("break", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(2*OS);
    check("break exit busy", busy, 1'b0);
    send_frame(8'h55, 1'b1);
    check_all("after break", 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    ack_pulse();
    check_all("ferr ack", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back frames without a read
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    check_all("overrun", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
    ack_pulse();
    check_all("overrun ack", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

    // Read acknowledged on the exact completion edge
    send_frame(8'h33, 1'b1);
    check("pre 7e data_out", data_out, 8'h33);
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (152) @(negedge clk);
        rd_ack = 1'b1;
        @(negedge clk);
        rd_ack = 1'b0;
      end
    join
    check_all("ack on done", 8'h7E, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset pulse during data bit 4
    part = 5'b01010;
    serial_in = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = part[i];
      repeat (OS) @(negedge clk);
    end
    serial_in = part[4];
    repeat (OS/2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    serial_in = 1'b1;
    check_all("mid reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2*OS);
    send_frame(8'h81, 1'b1);
    check_all("after reset", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(4);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
